load_use_scoreboard: RTL

Parametrised load-use hazard controller for the 5-stage pipeline, sitting beside the ID stage and driving PC hold, IF/ID hold and the ID/EX bubble. It generalises the single-cycle load-use check into a per-register scoreboard: every issued load marks its destination busy for LOAD_LAT cycles, and any ID instruction reading a busy register stalls. It also adds a global freeze for memory-side stalls, ignores register 0, and honours branch flushes.

---
 rtl/load_use_scoreboard.sv | 98 +++++++++
 1 files changed

// File: rtl/load_use_scoreboard.sv
// Per-register load-use scoreboard driving PC hold, IF/ID hold and the ID/EX bubble.
// Optional HAZARD_STATS_EN adds stall_cnt_o, a saturating count of load-use stall cycles.
module load_use_scoreboard #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     id_valid_i,
  input  logic [REG_AW-1:0]        id_rs_i,
  input  logic [REG_AW-1:0]        id_rt_i,
  input  logic                     id_rs_used_i,
  input  logic                     id_rt_used_i,
  input  logic                     id_memread_i,
  input  logic [REG_AW-1:0]        id_rd_i,
  input  logic                     flush_i,
  input  logic                     mem_stall_i,
  output logic                     pc_hold_o,
  output logic                     if_id_hold_o,
  output logic                     id_ex_valid_o,
  output logic [(1<<REG_AW)-1:0]   busy_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]              stall_cnt_o
`endif
);

  localparam int unsigned NumRegs = 1 << REG_AW;
  localparam logic [2:0]  LoadLat = 3'(LOAD_LAT);

  logic [2:0]         cnt_q [NumRegs];
  logic [2:0]         cnt_d [NumRegs];
  logic [NumRegs-1:0] busy;

  logic rs_hit, rt_hit;
  logic hazard, stall, hold, issue, load_issue;

  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      busy[i] = (cnt_q[i] != 3'd0);
    end
  end

  assign rs_hit     = id_rs_used_i & (id_rs_i != '0) & busy[id_rs_i];
  assign rt_hit     = id_rt_used_i & (id_rt_i != '0) & busy[id_rt_i];
  assign hazard     = id_valid_i & (rs_hit | rt_hit);
  // A squashed instruction is discarded anyway, so it must not hold the front end.
  assign stall      = hazard & ~flush_i;
  assign hold       = stall | mem_stall_i;
  assign issue      = id_valid_i & ~stall & ~flush_i & ~mem_stall_i;
  assign load_issue = issue & id_memread_i;

  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!mem_stall_i && (cnt_q[i] != 3'd0)) begin
        cnt_d[i] = cnt_q[i] - 3'd1;
      end
      // A new load to the same register restarts its window.
      if (load_issue && (id_rd_i != '0) && (id_rd_i == REG_AW'(i))) begin
        cnt_d[i] = LoadLat;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NumRegs; i++) begin
        cnt_q[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Outputs are forced low while reset is asserted.
  assign pc_hold_o     = rst_i & hold;
  assign if_id_hold_o  = rst_i & hold;
  assign id_ex_valid_o = rst_i & issue;
  assign busy_o        = rst_i ? busy : '0;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= 32'd0;
    end else if (stall && !mem_stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
